sp_dram_word_port: RTL and testbench

//   Word-granular access port in front of sp_dram: turns WIDTH-bit word reads and writes into
//   128-bit line commands with byte masks. Keeps one line in a read buffer, so sequential reads

---
 rtl/sp_mem_pkg.sv | 18 +
 rtl/sp_line_lane.sv | 40 ++++
 rtl/sp_dram_word_port.sv | 190 +++++++++++++++++++
 tb/tb_sp_dram_word_port.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_mem_pkg.sv
// Shared constants and state encoding for the sp_dram word port.
// LINE_WIDTH / LINE_BYTES describe one sp_dram line, MEM_ADDR_WIDTH is the
// line address width, and state_e is the port controller state.
package sp_mem_pkg;

  localparam int LINE_WIDTH     = 128;
  localparam int LINE_BYTES     = 16;
  localparam int MEM_ADDR_WIDTH = 26;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_ISSUE = 3'd2,
    RD_GAP   = 3'd3,
    RD_WAIT  = 3'd4
  } state_e;

endpackage

// File: rtl/sp_line_lane.sv
// Combinational word lane for one 128-bit line.
//   line_i  : source line
//   sel_i   : word index within the line
//   word_i  : word to insert at sel_i
//   word_o  : word sel_i extracted from line_i
//   line_o  : line_i with word sel_i replaced by word_i
//   mask_o  : byte enables covering word sel_i (bit b = byte b)
module sp_line_lane
  import sp_mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2
) (
  input  logic [LINE_WIDTH-1:0] line_i,
  input  logic [SEL_W-1:0]      sel_i,
  input  logic [WIDTH-1:0]      word_i,
  output logic [WIDTH-1:0]      word_o,
  output logic [LINE_WIDTH-1:0] line_o,
  output logic [LINE_BYTES-1:0] mask_o
);

  localparam int NWORDS = LINE_WIDTH / WIDTH;
  localparam int WBYTES = WIDTH / 8;

  // One-hot walk over the word slots keeps every slice constant, so all
  // legal widths (including the single-word 128-bit case) elaborate cleanly.
  always_comb begin
    word_o = '0;
    line_o = line_i;
    mask_o = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (sel_i == SEL_W'(k)) begin
        word_o                     = line_i[k*WIDTH +: WIDTH];
        line_o[k*WIDTH +: WIDTH]   = word_i;
        mask_o[k*WBYTES +: WBYTES] = '1;
      end
    end
  end

endmodule

// File: rtl/sp_dram_word_port.sv
// Word-granular access port in front of sp_dram.
// Converts WIDTH-bit word reads/writes into 128-bit line commands with byte
// masks, and keeps one write-through line buffer so repeated reads from the
// same line are served without a DRAM access.
//   clk, rst          : clock and synchronous active-high reset
//   addr, din, re, we : word request side (accepted only while ready_out)
//   dout, valid_out   : read data and its one-cycle valid pulse
//   ready_out         : port idle
//   mem_*             : line command interface to sp_dram
module sp_dram_word_port
  import sp_mem_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SEL_BITS   = $clog2(LINE_WIDTH / WIDTH),
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH + SEL_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [WIDTH-1:0]          din,
  input  logic                      re,
  input  logic                      we,
  output logic [WIDTH-1:0]          dout,
  output logic                      valid_out,
  output logic                      ready_out,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0]     mem_din,
  input  logic [LINE_WIDTH-1:0]     mem_dout,
  output logic [LINE_BYTES-1:0]     mem_mask,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic                      mem_ready
);

  localparam int SEL_W  = (SEL_BITS > 0) ? SEL_BITS : 1;
  localparam int NWORDS = LINE_WIDTH / WIDTH;

  state_e                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] line_q, line_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic [WIDTH-1:0]          din_q, din_d;
  logic [LINE_WIDTH-1:0]     buf_q, buf_d;
  logic [MEM_ADDR_WIDTH-1:0] tag_q, tag_d;
  logic                      bufValid_q, bufValid_d;
  logic [WIDTH-1:0]          dout_q, dout_d;
  logic                      valid_q, valid_d;

  logic [MEM_ADDR_WIDTH-1:0] reqLine;
  logic [SEL_W-1:0]          reqSel;
  logic                      bufHit;
  logic [LINE_WIDTH-1:0]     laneLine;
  logic [SEL_W-1:0]          laneSel;
  logic [WIDTH-1:0]          laneWord;
  logic [LINE_WIDTH-1:0]     laneInserted;
  logic [LINE_BYTES-1:0]     laneMask;

  assign reqLine = addr[ADDR_WIDTH-1 -: MEM_ADDR_WIDTH];

  generate
    if (SEL_BITS > 0) begin : gSel
      assign reqSel = addr[SEL_W-1:0];
    end else begin : gNoSel
      assign reqSel = '0;
    end
  endgenerate

  assign bufHit = bufValid_q && (tag_q == reqLine);

  // A single lane serves every state: in IDLE it reads/patches the buffer at
  // the incoming select, in RD_WAIT it picks the word out of the returning
  // DRAM line, and in WRITE it supplies the byte mask for the latched select.
  assign laneLine = (state_q == RD_WAIT) ? mem_dout : buf_q;
  assign laneSel  = (state_q == IDLE) ? reqSel : sel_q;

  sp_line_lane #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) uLane (
    .line_i (laneLine),
    .sel_i  (laneSel),
    .word_i (din),
    .word_o (laneWord),
    .line_o (laneInserted),
    .mask_o (laneMask)
  );

  assign dout      = dout_q;
  assign valid_out = valid_q;
  assign ready_out = (state_q == IDLE) && !rst;
  assign mem_addr  = line_q;

  // Next-state and DRAM command logic. Writes win over simultaneous reads;
  // the DRAM strobes follow mem_ready directly so each fires for exactly the
  // one cycle sp_dram accepts it.
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    sel_d      = sel_q;
    din_d      = din_q;
    buf_d      = buf_q;
    tag_d      = tag_q;
    bufValid_d = bufValid_q;
    dout_d     = dout_q;
    valid_d    = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_din    = '0;
    mem_mask   = '0;
    case (state_q)
      IDLE: begin
        if (we) begin
          line_d  = reqLine;
          sel_d   = reqSel;
          din_d   = din;
          if (bufHit) begin
            buf_d = laneInserted;
          end
          state_d = WRITE;
        end else if (re) begin
          if (bufHit) begin
            dout_d  = laneWord;
            valid_d = 1'b1;
          end else begin
            line_d  = reqLine;
            sel_d   = reqSel;
            state_d = RD_ISSUE;
          end
        end
      end
      WRITE: begin
        mem_we   = mem_ready && !rst;
        mem_din  = {NWORDS{din_q}};
        mem_mask = laneMask;
        if (mem_ready) begin
          state_d = IDLE;
        end
      end
      RD_ISSUE: begin
        mem_re = mem_ready && !rst;
        if (mem_ready) begin
          state_d = RD_GAP;
        end
      end
      // sp_dram still shows ready for one cycle after accepting a read.
      RD_GAP: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_ready) begin
          buf_d      = mem_dout;
          tag_d      = line_q;
          bufValid_d = 1'b1;
          dout_d     = laneWord;
          valid_d    = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any request in progress and
  // invalidates the buffer because sp_dram drops its in-flight reads too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      line_q     <= '0;
      sel_q      <= '0;
      din_q      <= '0;
      buf_q      <= '0;
      tag_q      <= '0;
      bufValid_q <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      sel_q      <= sel_d;
      din_q      <= din_d;
      buf_q      <= buf_d;
      tag_q      <= tag_d;
      bufValid_q <= bufValid_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_sp_dram_word_port.sv
// Bench for sp_dram_word_port: directed scenarios followed by random
// read/write traffic, with an sp_dram behavioural model and a word-level
// reference memory.
module tb_sp_dram_word_port;

  logic         clk;
  logic         rst;
  logic [27:0]  addr;
  logic [31:0]  din;
  logic         re;
  logic         we;
  logic [31:0]  dout;
  logic         valid_out;
  logic         ready_out;
  logic [25:0]  mem_addr;
  logic [127:0] mem_din;
  logic [127:0] mem_dout;
  logic [15:0]  mem_mask;
  logic         mem_we;
  logic         mem_re;
  logic         mem_ready;

  sp_dram_word_port dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .din       (din),
    .re        (re),
    .we        (we),
    .dout      (dout),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .mem_mask  (mem_mask),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCount = 0;
  int checkCount = 0;

  // Bench-side bookkeeping
  logic [127:0] dramMem [int];
  logic [31:0]  refMem [int];
  int           dramLatency = 3;
  int           dramPhase = 0;
  int           dramCnt = 0;
  int           dramPendLine = 0;
  int           reCount = 0;
  int           weCount = 0;
  int           validCount = 0;
  int           bothCount = 0;
  logic [25:0]  lastReAddr = '0;
  logic [25:0]  lastWeAddr = '0;
  logic [15:0]  lastMask = '0;
  logic [127:0] lastDin = '0;
  bit           tbBufValid = 0;
  logic [25:0]  tbBufLine = '0;

  function automatic logic [31:0] initWord(input logic [27:0] a);
    if (a[27:2] == 26'd5) return 32'h11111111 * 32'(a[1:0]);
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  function automatic logic [127:0] initLine(input logic [25:0] l);
    logic [127:0] v;
    for (int k = 0; k < 4; k++) v[k*32 +: 32] = initWord({l, 2'(k)});
    return v;
  endfunction

  function automatic logic [31:0] expWord(input logic [27:0] a);
    if (refMem.exists(int'(a))) return refMem[int'(a)];
    return initWord(a);
  endfunction

  // sp_dram model: stays ready one cycle after accepting a read, then low
  // for dramLatency cycles, then returns the line with ready high.
  always @(posedge clk) begin
    if (rst) begin
      mem_ready <= 1'b1;
      dramPhase = 0;
    end else begin
      if (mem_we && mem_ready) begin
        logic [127:0] l;
        l = dramMem.exists(int'(mem_addr)) ? dramMem[int'(mem_addr)] : initLine(mem_addr);
        for (int b = 0; b < 16; b++) if (mem_mask[b]) l[b*8 +: 8] = mem_din[b*8 +: 8];
        dramMem[int'(mem_addr)] = l;
      end
      case (dramPhase)
        0: if (mem_re && mem_ready) begin
          dramPendLine = int'(mem_addr);
          dramPhase = 1;
        end
        1: begin
          mem_ready <= 1'b0;
          dramCnt = dramLatency;
          dramPhase = 2;
        end
        default: begin
          if (dramCnt > 1) dramCnt--;
          else begin
            mem_ready <= 1'b1;
            mem_dout <= dramMem.exists(dramPendLine) ? dramMem[dramPendLine]
                                                     : initLine(26'(dramPendLine));
            dramPhase = 0;
          end
        end
      endcase
    end
  end

  // Event monitor
  always @(negedge clk) begin
    if (mem_re === 1'b1) begin reCount++; lastReAddr = mem_addr; end
    if (mem_we === 1'b1) begin
      weCount++; lastWeAddr = mem_addr; lastMask = mem_mask; lastDin = mem_din;
    end
    if (valid_out === 1'b1) validCount++;
    if (mem_re === 1'b1 && mem_we === 1'b1) bothCount++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(negedge clk); #1; end
  endtask

  task automatic applyStimulus(input logic [27:0] a, input logic [31:0] d, input bit r, input bit w);
    @(negedge clk);
    addr = a; din = d; re = r; we = w;
    @(negedge clk);
    re = 1'b0; we = 1'b0;
    #1;
  endtask

  task automatic doRead(input string tag, input logic [27:0] a);
    int re0, cycles, expLat;
    bit miss;
    logic [31:0] exp;
    miss = !(tbBufValid && tbBufLine == a[27:2]);
    exp = expWord(a);
    expLat = miss ? 4 + dramLatency : 1;
    re0 = reCount;
    applyStimulus(a, 32'h0, 1'b1, 1'b0);
    cycles = 1;
    while (valid_out !== 1'b1 && cycles < 300) begin @(negedge clk); #1; cycles++; end
    checkOutput({tag, ".valid"}, 128'(valid_out), 128'(1));
    checkOutput({tag, ".dout"}, 128'(dout), 128'(exp));
    checkOutput({tag, ".latency"}, 128'(cycles), 128'(expLat));
    checkOutput({tag, ".memRe"}, 128'(reCount - re0), 128'(miss));
    if (miss) checkOutput({tag, ".memAddr"}, 128'(lastReAddr), 128'(a[27:2]));
    tbBufValid = 1; tbBufLine = a[27:2];
  endtask

  task automatic doWrite(input string tag, input logic [27:0] a, input logic [31:0] d, input bit withRe);
    int re0, we0, v0, cycles;
    re0 = reCount; we0 = weCount; v0 = validCount;
    applyStimulus(a, d, withRe, 1'b1);
    cycles = 0;
    while (weCount == we0 && cycles < 300) begin @(negedge clk); #1; cycles++; end
    tick(3);
    checkOutput({tag, ".memWe"}, 128'(weCount - we0), 128'(1));
    checkOutput({tag, ".mask"}, 128'(lastMask), 128'(16'h000F << (4 * int'(a[1:0]))));
    checkOutput({tag, ".memAddr"}, 128'(lastWeAddr), 128'(a[27:2]));
    checkOutput({tag, ".memDin"}, lastDin, {4{d}});
    checkOutput({tag, ".noRead"}, 128'(reCount - re0), 128'(0));
    checkOutput({tag, ".noValid"}, 128'(validCount - v0), 128'(0));
    refMem[int'(a)] = d;
  endtask

  initial begin : main
    int re0, we0, v0, cycles;
    int unsigned lineSet [4];
    logic [27:0] ra;
    lineSet = '{32'd5, 32'd8, 32'd12, 32'h3FFFFFF};
    rst = 1'b1; addr = '0; din = '0; re = 1'b0; we = 1'b0;
    mem_dout = '0; mem_ready = 1'b1;

    // Reset and release
    tick(3);
    checkOutput("rst.ready", 128'(ready_out), 128'(0));
    checkOutput("rst.valid", 128'(valid_out), 128'(0));
    checkOutput("rst.memRe", 128'(mem_re), 128'(0));
    checkOutput("rst.memWe", 128'(mem_we), 128'(0));
    checkOutput("rst.dout", 128'(dout), 128'(0));
    @(negedge clk); rst = 1'b0;
    tick(1);
    checkOutput("rel.ready", 128'(ready_out), 128'(1));
    tick(4);
    checkOutput("rel.quiet", 128'(reCount + weCount + validCount), 128'(0));

    // Miss then hit on line 5
    doRead("miss16", 28'h16);
    doRead("hit17", 28'h17);

    // Write-through to the buffered line
    doWrite("wr15", 28'h15, 32'hDEADBEEF, 1'b0);
    doRead("hit15", 28'h15);

    // Long DRAM stall with ignored requests in the middle
    dramLatency = 25;
    re0 = reCount; we0 = weCount; v0 = validCount;
    applyStimulus(28'h24, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 8)  begin addr = 28'h24; din = 32'h0BAD; we = 1'b1; end
      if (i == 9)  we = 1'b0;
      if (i == 12) begin addr = 28'h30; re = 1'b1; end
      if (i == 13) re = 1'b0;
      @(negedge clk); #1;
      if (i % 5 == 4) checkOutput("stall.ready", 128'(ready_out), 128'(0));
    end
    cycles = 0;
    while (valid_out !== 1'b1 && cycles < 300) begin @(negedge clk); #1; cycles++; end
    checkOutput("stall.dout", 128'(dout), 128'(expWord(28'h24)));
    tick(6);
    checkOutput("stall.validOnce", 128'(validCount - v0), 128'(1));
    checkOutput("stall.readOnce", 128'(reCount - re0), 128'(1));
    checkOutput("stall.noWrite", 128'(weCount - we0), 128'(0));
    tbBufValid = 1; tbBufLine = 26'h9;
    dramLatency = 3;

    // Simultaneous re/we acts as a write
    doWrite("reWe20", 28'h20, 32'h1, 1'b1);
    doRead("rd20", 28'h20);

    // Reset while waiting on DRAM
    dramLatency = 10;
    re0 = reCount; v0 = validCount;
    applyStimulus(28'h30, 32'h0, 1'b1, 1'b0);
    tick(6);
    @(negedge clk); rst = 1'b1;
    tick(2);
    @(negedge clk); rst = 1'b0;
    tick(15);
    checkOutput("rstWait.noValid", 128'(validCount - v0), 128'(0));
    checkOutput("rstWait.oneRead", 128'(reCount - re0), 128'(1));
    tbBufValid = 0;
    dramLatency = 3;
    doRead("afterRst20", 28'h20);

    // Top line of the address space
    doRead("topLine", 28'hFFFFFFF);

    // Random traffic
    for (int n = 0; n < 30; n++) begin
      ra = {lineSet[$urandom_range(0, 3)][25:0], 2'($urandom_range(0, 3))};
      dramLatency = int'($urandom_range(1, 6));
      if ($urandom_range(0, 9) < 7) doRead("rndRd", ra);
      else doWrite("rndWr", ra, $urandom, 1'($urandom_range(0, 1)));
    end

    checkOutput("neverBoth", 128'(bothCount), 128'(0));
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
